// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned AW_DEF         = 32;
    localparam int unsigned DW_DEF         = 32;
    localparam int unsigned OPW_DEF        = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Op encoding presented to memory for every instruction fetch.
    localparam int unsigned OP_WORD_READ = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, data port and unified memory port signals.
// slave: the arbiter's view. master: the core + memory environment's view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned OPW = OPW_DEF
) ();

    logic           i_req;
    logic [AW-1:0]  i_addr;
    logic           i_stall;
    logic           i_valid;
    logic [DW-1:0]  i_rdata;

    logic           d_req;
    logic           d_we;
    logic [AW-1:0]  d_addr;
    logic [DW-1:0]  d_wdata;
    logic [OPW-1:0] d_op;
    logic           d_stall;
    logic           d_valid;
    logic [DW-1:0]  d_rdata;

    logic           mem_req;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [OPW-1:0] mem_op;
    logic [DW-1:0]  mem_rdata;
    logic           mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_op, mem_rdata, mem_ready,
        output i_stall, i_valid, i_rdata, d_stall, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_op
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_op, mem_rdata, mem_ready,
        input  i_stall, i_valid, i_rdata, d_stall, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_op
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while fetch is waiting.
module arb_starve_ctr #(
    parameter int unsigned MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam int unsigned CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign at_max = (cnt_q == CW'(MAX_COUNT));

    // Clear wins over increment; increment stops at MAX_COUNT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch and data ports of the core.
// Data has priority; after STARVE_MAX back-to-back data grants with fetch waiting,
// the next grant goes to fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned OPW        = OPW_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e     state_q, state_d;
    logic           grant_i, grant_d;
    logic           starve_at_max;
    logic           i_done, d_done;

    logic           mem_req_q;
    logic           mem_we_q;
    logic [AW-1:0]  mem_addr_q;
    logic [DW-1:0]  mem_wdata_q;
    logic [OPW-1:0] mem_op_q;
    logic           i_valid_q, d_valid_q;
    logic [DW-1:0]  i_rdata_q, d_rdata_q;

    // mem_ready outside a BUSY state is ignored.
    assign i_done = (state_q == StBusyI) && bus.mem_ready;
    assign d_done = (state_q == StBusyD) && bus.mem_ready;

    arb_starve_ctr #(
        .MAX_COUNT (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (!bus.i_req || grant_i),
        .inc    (grant_d && bus.i_req),
        .at_max (starve_at_max)
    );

    // Arbitration only in IDLE; RESP always returns to IDLE so valid never overlaps a grant.
    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.d_req && (!bus.i_req || !starve_at_max)) begin
                    grant_d = 1'b1;
                    state_d = StBusyD;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                    state_d = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (bus.mem_ready) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register and one-cycle valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_valid_q <= i_done;
            d_valid_q <= d_done;
        end
    end

    // Memory request registers: loaded on grant, held until completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_op_q    <= '0;
        end else if (grant_d) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_op_q    <= bus.d_op;
        end else if (grant_i) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_op_q    <= OPW'(OP_WORD_READ);
        end else if (i_done || d_done) begin
            mem_req_q   <= 1'b0;
        end
    end

    // Read data capture; stores leave d_rdata untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (i_done) begin
                i_rdata_q <= bus.mem_rdata;
            end
            if (d_done && !mem_we_q) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_op    = mem_op_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_stall   = bus.i_req && !i_valid_q;
    assign bus.d_stall   = bus.d_req && !d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple wait-state memory responder.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Memory responder state.
    int          wait_cycles = 0;
    int          wcnt        = 0;
    int          both_valid  = 0;
    logic [31:0] log_addr[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h2002_0005;
        return 32'hA500_0000 ^ a;
    endfunction

    // Memory: ready after wait_cycles BUSY cycles; logs every completed address.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.i_valid && bus.d_valid) both_valid++;
            if (rst || !bus.mem_req) begin
                bus.mem_ready = 1'b0;
                wcnt = 0;
            end else if (wcnt >= wait_cycles) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
                log_addr.push_back(bus.mem_addr);
                wcnt = 0;
            end else begin
                bus.mem_ready = 1'b0;
                wcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
        n_vec++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 0", bus.mem_we); end
        n_vec++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
        n_vec++; if ({bus.i_valid, bus.d_valid} !== 2'b00) begin n_err++; $display("FAIL rst_valid got %b want 00", {bus.i_valid, bus.d_valid}); end
        n_vec++; if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h/%h want 0/0", bus.i_rdata, bus.d_rdata); end
        rst = 1'b0;
        tick();
    endtask

    // Valid must land in the 3rd cycle counting the request cycle as the 1st.
    task automatic test_single_fetch();
        int n;
        wait_cycles = 0;
        bus.i_addr = 32'h4;
        bus.i_req  = 1'b1;
        tick();
        n = 1;
        n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin n_err++; $display("FAIL fetch_req got req=%b addr=%h want 1/00000004", bus.mem_req, bus.mem_addr); end
        n_vec++; if (bus.mem_we !== 1'b0 || bus.mem_op !== 32'h0 || bus.mem_wdata !== 32'h0) begin n_err++; $display("FAIL fetch_fields got we=%b op=%h wd=%h want 0/0/0", bus.mem_we, bus.mem_op, bus.mem_wdata); end
        n_vec++; if (bus.i_stall !== 1'b1) begin n_err++; $display("FAIL fetch_stall got %b want 1", bus.i_stall); end
        while (!bus.i_valid && n < 20) begin tick(); n++; end
        n_vec++; if (n !== 2) begin n_err++; $display("FAIL fetch_latency got %0d edges want 2", n); end
        n_vec++; if (bus.i_rdata !== 32'h2002_0005) begin n_err++; $display("FAIL fetch_rdata got %h want 20020005", bus.i_rdata); end
        n_vec++; if (bus.i_stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall_at_valid got %b want 0", bus.i_stall); end
        bus.i_req = 1'b0;
        tick();
        n_vec++; if (bus.i_valid !== 1'b0) begin n_err++; $display("FAIL fetch_pulse got %b want 0", bus.i_valid); end
        tick();
    endtask

    task automatic test_conflict();
        int n, d_at, i_at;
        n = 0; d_at = -1; i_at = -1;
        bus.i_addr = 32'h8;
        bus.d_addr = 32'h50; bus.d_we = 1'b0; bus.d_op = 32'h0; bus.d_wdata = 32'h0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        while ((d_at < 0 || i_at < 0) && n < 40) begin
            tick(); n++;
            if (bus.d_valid) begin d_at = n; bus.d_req = 1'b0; end
            if (bus.i_valid) begin i_at = n; bus.i_req = 1'b0; end
        end
        n_vec++; if (d_at !== 2) begin n_err++; $display("FAIL conflict_d_at got %0d want 2", d_at); end
        n_vec++; if (i_at !== 5) begin n_err++; $display("FAIL conflict_i_at got %0d want 5", i_at); end
        n_vec++; if (bus.d_rdata !== 32'hA500_0050) begin n_err++; $display("FAIL conflict_d_rdata got %h want a5000050", bus.d_rdata); end
        n_vec++; if (bus.i_rdata !== 32'hA500_0008) begin n_err++; $display("FAIL conflict_i_rdata got %h want a5000008", bus.i_rdata); end
        tick();
        tick();
    endtask

    task automatic test_starvation();
        int n, base;
        logic [31:0] exp_addr;
        n = 0;
        base = log_addr.size();
        bus.i_addr = 32'h100;
        bus.d_addr = 32'h200; bus.d_we = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        while (n < 100) begin
            tick(); n++;
            if (bus.i_valid) bus.i_req = 1'b0;
            if (log_addr.size() - base >= 6) break;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (log_addr.size() - base !== 6) begin n_err++; $display("FAIL starve_count got %0d grants want 6", log_addr.size() - base); end
        for (int k = 0; k < 6; k++) begin
            exp_addr = (k == 4) ? 32'h100 : 32'h200;
            n_vec++;
            if (base + k >= log_addr.size()) begin
                n_err++; $display("FAIL starve_order[%0d] got none want %h", k, exp_addr);
            end else if (log_addr[base + k] !== exp_addr) begin
                n_err++; $display("FAIL starve_order[%0d] got %h want %h", k, log_addr[base + k], exp_addr);
            end
        end
    endtask

    task automatic test_wait_states();
        wait_cycles = 5;
        bus.d_addr = 32'h60; bus.d_we = 1'b0; bus.d_op = 32'h0;
        bus.d_req = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h60 || bus.d_stall !== 1'b1 || bus.d_valid !== 1'b0) begin
                n_err++; $display("FAIL wait_hold[%0d] got req=%b addr=%h stall=%b valid=%b want 1/00000060/1/0", k, bus.mem_req, bus.mem_addr, bus.d_stall, bus.d_valid);
            end
            tick();
        end
        n_vec++; if (bus.d_valid !== 1'b0 || bus.mem_req !== 1'b1) begin n_err++; $display("FAIL wait_ready_cycle got valid=%b req=%b want 0/1", bus.d_valid, bus.mem_req); end
        tick();
        n_vec++; if (bus.d_valid !== 1'b1 || bus.d_stall !== 1'b0) begin n_err++; $display("FAIL wait_valid got valid=%b stall=%b want 1/0", bus.d_valid, bus.d_stall); end
        n_vec++; if (bus.d_rdata !== 32'hA500_0060) begin n_err++; $display("FAIL wait_rdata got %h want a5000060", bus.d_rdata); end
        bus.d_req = 1'b0;
        wait_cycles = 0;
        tick();
        tick();
    endtask

    task automatic test_store();
        bus.d_addr = 32'h54; bus.d_we = 1'b1; bus.d_wdata = 32'hDEAD_BEEF; bus.d_op = 32'h1;
        bus.d_req = 1'b1;
        tick();
        n_vec++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_err++; $display("FAIL store_req got req=%b we=%b want 1/1", bus.mem_req, bus.mem_we); end
        n_vec++; if (bus.mem_addr !== 32'h54 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_op !== 32'h1) begin n_err++; $display("FAIL store_fields got %h/%h/%h want 00000054/deadbeef/00000001", bus.mem_addr, bus.mem_wdata, bus.mem_op); end
        tick();
        n_vec++; if (bus.d_valid !== 1'b1) begin n_err++; $display("FAIL store_valid got %b want 1", bus.d_valid); end
        n_vec++; if (bus.d_rdata !== 32'hA500_0060) begin n_err++; $display("FAIL store_rdata_kept got %h want a5000060", bus.d_rdata); end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int n, vseen;
        wait_cycles = 10;
        bus.d_addr = 32'h70; bus.d_we = 1'b0; bus.d_op = 32'h0;
        bus.d_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_vec++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL midrst_mem got req=%b addr=%h want 0/0", bus.mem_req, bus.mem_addr); end
        n_vec++; if (bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_rdata got %h/%h want 0/0", bus.d_rdata, bus.i_rdata); end
        rst = 1'b0;
        bus.d_req = 1'b0;
        vseen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.d_valid || bus.i_valid || bus.mem_req) vseen++;
        end
        n_vec++; if (vseen !== 0) begin n_err++; $display("FAIL midrst_quiet got %0d active cycles want 0", vseen); end
        wait_cycles = 0;
        bus.i_addr = 32'h4;
        bus.i_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.i_valid && n < 20);
        n_vec++; if (n !== 2 || bus.i_rdata !== 32'h2002_0005) begin n_err++; $display("FAIL midrst_fetch got %0d edges rdata=%h want 2/20020005", n, bus.i_rdata); end
        bus.i_req = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_op = '0;
        test_reset();
        test_single_fetch();
        test_conflict();
        test_starvation();
        test_wait_states();
        test_store();
        test_reset_mid_busy();
        n_vec++; if (both_valid !== 0) begin n_err++; $display("FAIL both_valid got %0d cycles want 0", both_valid); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
